beta_dmem: RTL and testbench

BETA_DMEM -- requirements
Module: beta_dmem

---
 rtl/beta_dmem.sv | 110 +++++++++++
 tb/tb_beta_dmem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/beta_dmem.sv
// Beta data memory: word-addressed 32-bit array behind a stall handshake with
// optional wait states, range/alignment error flag and registered read data.
module beta_dmem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        mwr,
    input  logic        moe,
    output logic [31:0] rd,
    output logic        stall,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam int         DEPTH     = 1 << ADDR_W;

    logic [31:0]       mem_q [0:DEPTH-1];
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rd_q, rd_d;
    logic              err_q, err_d;

    logic              req;
    logic              oob;
    logic              mis;
    logic              perform;
    logic [ADDR_W-1:0] word;

    assign req  = mwr | moe;
    assign word = addr[ADDR_W+1:2];
    assign oob  = (addr[31:ADDR_W+2] != '0);
    assign mis  = (addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perform = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        perform = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Dropping the request mid-wait is a pipeline flush: abandon quietly.
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    perform = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d  = rd_q;
        err_d = err_q;
        if (perform) begin
            err_d = oob | mis;
            if (!mwr) begin
                rd_d = oob ? 32'd0 : mem_q[word];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // The array is never reset; rst_n only gates the write so a reset aborts it.
    always_ff @(posedge clk) begin
        if (perform && mwr && !oob && rst_n) begin
            mem_q[word] <= wd;
        end
    end

    assign rd    = rd_q;
    assign err   = err_q;
    assign stall = req & (state_q != DONE);

endmodule

// File: tb/tb_beta_dmem.sv
// Scoreboard bench for beta_dmem: a zero-wait instance (index 0) and a
// two-wait-state instance (index 1), driven one at a time.
module tb_beta_dmem;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } Expect;

    logic        clk;
    logic        rst_n;
    logic [31:0] addrS  [2];
    logic [31:0] wdS    [2];
    logic        mwrS   [2];
    logic        moeS   [2];
    logic [31:0] rdS    [2];
    logic        stallS [2];
    logic        errS   [2];

    int          checks   = 0;
    int          failures = 0;
    Expect       expQ[$];
    logic [31:0] modelMem [int];
    logic [31:0] lastRd  [2];
    logic        lastErr [2];

    beta_dmem #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dmem0 (
        .clk(clk), .rst_n(rst_n), .addr(addrS[0]), .wd(wdS[0]), .mwr(mwrS[0]),
        .moe(moeS[0]), .rd(rdS[0]), .stall(stallS[0]), .err(errS[0])
    );

    beta_dmem #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dmem2 (
        .clk(clk), .rst_n(rst_n), .addr(addrS[1]), .wd(wdS[1]), .mwr(mwrS[1]),
        .moe(moeS[1]), .rd(rdS[1]), .stall(stallS[1]), .err(errS[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // A completed access is visible while the request is held and stall is low.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst_n && (mwrS[s] | moeS[s]) && !stallS[s]) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    Expect e;
                    e = expQ.pop_front();
                    checkOutput({e.name, "_rd"}, rdS[s], e.rd);
                    checkOutput({e.name, "_err"}, {31'd0, errS[s]}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r, input int expStalls,
                                 input string name);
        Expect e;
        int    key;
        int    stalls;
        bit    done;
        logic  oob;
        key     = sel * 4096 + int'(a[11:2]);
        oob     = (a[31:12] != 20'd0);
        e.err   = oob | (a[1:0] != 2'b00);
        e.name  = name;
        if (w) begin
            if (!oob) modelMem[key] = d;
            e.rd = lastRd[sel];
        end else begin
            e.rd = oob ? 32'd0 : (modelMem.exists(key) ? modelMem[key] : 32'd0);
        end
        lastRd[sel]  = e.rd;
        lastErr[sel] = e.err;
        expQ.push_back(e);

        addrS[sel] = a;
        wdS[sel]   = d;
        mwrS[sel]  = w;
        moeS[sel]  = r;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stallS[sel]) stalls++;
            else done = 1'b1;
        end
        if (!done) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
        checkOutput({name, "_stalls"}, stalls, expStalls);
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus(input int sel);
        mwrS[sel] = 1'b0;
        moeS[sel] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            addrS[s] = 32'd0; wdS[s] = 32'd0; mwrS[s] = 1'b0; moeS[s] = 1'b0;
            lastRd[s] = 32'd0; lastErr[s] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("resetRd", rdS[s], 32'd0);
            checkOutput("resetErr", {31'd0, errS[s]}, 32'd0);
            checkOutput("resetStallIdle", {31'd0, stallS[s]}, 32'd0);
        end
        moeS[0] = 1'b1;
        #1;
        checkOutput("resetStallReq", {31'd0, stallS[0]}, 32'd1);
        repeat (2) @(negedge clk);
        moeS[0] = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait instance: back-to-back reads, oob, misalignment, write priority.
        applyStimulus(0, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1, 1'b0, 1, "w0");
        applyStimulus(0, 32'h0000_0004, 32'h5A5A_5A5A, 1'b1, 1'b0, 1, "w4");
        idleBus(0);
        applyStimulus(0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1, "b2bRead0");
        applyStimulus(0, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 1, "b2bRead4");
        idleBus(0);
        applyStimulus(0, 32'h0000_1000, 32'hBADB_AD00, 1'b1, 1'b0, 1, "oobWrite");
        applyStimulus(0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 1, "oobRead");
        applyStimulus(0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1, "word0Kept");
        idleBus(0);
        applyStimulus(0, 32'h0000_0013, 32'h1313_1313, 1'b1, 1'b0, 1, "misWrite");
        applyStimulus(0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1, "alignedRead");
        idleBus(0);
        applyStimulus(0, 32'h0000_0008, 32'h0000_0005, 1'b1, 1'b1, 1, "bothWrite");
        idleBus(0);
        applyStimulus(0, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 1, "bothRead");
        idleBus(0);

        // Two-wait instance: stall length, flush and reset in BUSY.
        applyStimulus(1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, "waitWrite");
        idleBus(1);
        applyStimulus(1, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 3, "waitRead");
        idleBus(1);
        applyStimulus(1, 32'h0000_0020, 32'h1111_1111, 1'b1, 1'b0, 3, "w20");
        idleBus(1);

        addrS[1] = 32'h0000_0020; wdS[1] = 32'h2222_2222; mwrS[1] = 1'b1;
        @(posedge clk);
        #1;
        mwrS[1] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flushRd", rdS[1], lastRd[1]);
        checkOutput("flushErr", {31'd0, errS[1]}, {31'd0, lastErr[1]});
        applyStimulus(1, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 3, "flushNoWrite");
        applyStimulus(1, 32'h0000_0021, 32'h0, 1'b0, 1'b1, 3, "misRead");
        idleBus(1);

        addrS[1] = 32'h0000_0020; wdS[1] = 32'h3333_3333; mwrS[1] = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("busyResetRd", rdS[1], 32'd0);
        checkOutput("busyResetErr", {31'd0, errS[1]}, 32'd0);
        checkOutput("busyResetStall", {31'd0, stallS[1]}, 32'd1);
        mwrS[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lastRd[0] = 32'd0; lastRd[1] = 32'd0;
        @(posedge clk);
        #1;
        applyStimulus(1, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 3, "resetNoWrite");
        idleBus(1);

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
